// File: rtl/im_arbiter.sv
// im_arbiter: arbitrates one instruction-memory port between a fetch
// requester and a load (write) requester.
// The fetch requester reads with one cycle of latency.
// The load requester writes, and the block counts writes that succeed.
// Optional macro IM_ARB_RR_EN: when it is defined, simultaneous requests
// alternate between fetch and load. When it is not defined, fetch always wins.
module im_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  output logic                  f_err,
  input  logic                  l_valid,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  output logic                  l_ready,
  output logic                  l_err,
  output logic [15:0]           load_cnt,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned AW       = DEPTH_LOG2;
  localparam logic [32:0] SPAN     = 33'(33'd4 << DEPTH_LOG2);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  // Byte address must be aligned, at or above the base, and inside the memory window.
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && (addr[1:0] == 2'b00) && ({1'b0, off} < SPAN);
  endfunction

  // Word index: the offset from the base, in words, truncated to the memory depth.
  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  logic          f_in_range, l_in_range;
  logic          f_hit, l_hit;
  logic          f_rvalid_q, f_rvalid_d;
  logic          f_err_q, f_err_d;
  logic          l_err_q, l_err_d;
  logic [15:0]   load_cnt_q, load_cnt_d;
`ifdef IM_ARB_RR_EN
  logic          rr_q, rr_d;   // 0: fetch wins the next conflict, 1: load wins
`endif

  assign f_in_range = in_range(f_addr);
  assign l_in_range = in_range(l_addr);

  // Grant selection. A request with no competitor is always granted.
  always_comb begin
    f_gnt   = 1'b0;
    l_ready = 1'b0;
`ifdef IM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    if (f_req && l_valid) begin
`ifdef IM_ARB_RR_EN
      f_gnt   = ~rr_q;
      l_ready = rr_q;
      rr_d    = ~rr_q;
`else
      f_gnt   = 1'b1;
`endif
    end else begin
      f_gnt   = f_req;
      l_ready = l_valid;
    end
  end

  // Memory port. Out-of-range grants are acknowledged but never touch the RAM.
  assign f_hit     = f_gnt & f_in_range;
  assign l_hit     = l_ready & l_in_range;
  assign mem_en    = f_hit | l_hit;
  assign mem_we    = l_hit;
  assign mem_addr  = l_ready ? word_idx(l_addr) : word_idx(f_addr);
  assign mem_wdata = l_wdata;

  // Next-state values for the response flags and the saturating write counter.
  always_comb begin
    f_rvalid_d = f_gnt;
    f_err_d    = f_gnt & ~f_in_range;
    l_err_d    = l_ready & ~l_in_range;
    load_cnt_d = load_cnt_q;
    if (l_hit && (load_cnt_q != CNT_MAX)) begin
      load_cnt_d = load_cnt_q + 16'd1;
    end
  end

  // State registers. Reset also discards a read that is still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      l_err_q    <= 1'b0;
      load_cnt_q <= '0;
    end else begin
      f_rvalid_q <= f_rvalid_d;
      f_err_q    <= f_err_d;
      l_err_q    <= l_err_d;
      load_cnt_q <= load_cnt_d;
    end
  end

`ifdef IM_ARB_RR_EN
  // Round-robin pointer. It starts at fetch and flips after every conflict grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end
`endif

  // Read data comes straight from the RAM output register and is forced to zero otherwise.
  assign f_rvalid = f_rvalid_q;
  assign f_err    = f_err_q;
  assign f_rdata  = (f_rvalid_q && !f_err_q) ? mem_rdata : 32'h0;
  assign l_err    = l_err_q;
  assign load_cnt = load_cnt_q;

endmodule

// File: tb/tb_im_arbiter.sv
// tb_im_arbiter: directed bench for im_arbiter with a transaction-level model.
module tb_im_arbiter;

  localparam longint BASE  = 64'h3000;
  localparam int     WORDS = 4096;

  logic        clk, reset_n;
  logic        f_req, l_valid;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, f_err, l_ready, l_err;
  logic [31:0] f_rdata, mem_wdata, mem_rdata;
  logic [15:0] load_cnt;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;

  int n_chk  = 0;
  int n_pass = 0;

  im_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_valid(l_valid), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ready(l_ready), .l_err(l_err), .load_cnt(load_cnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM with a one-cycle read latency
  logic [31:0] ram [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) ram[i] = 32'h1000_0000 + 32'(i);
    ram[1] = 32'h2408_0001;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint v;
    v = longint'(a);
    return (v >= BASE) && (v % 4 == 0) && (v - BASE < 4 * WORDS);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - BASE) / 4);
  endfunction

  // ---- Transaction model: expected responses due and memory contents ----
  logic [31:0] gold [WORDS];
  bit          m_pend, m_perr, m_lerr, m_fetch_turn;
  logic [31:0] m_pdata;
  int          m_cnt;
  bit          nx_pend, nx_perr, nx_lerr, nx_turn, nx_we;
  logic [31:0] nx_pdata, nx_wdata;
  int          nx_cnt, nx_widx;
  bit          e_f, e_l, fin, lin;

  initial begin
    for (int i = 0; i < WORDS; i++) gold[i] = 32'h1000_0000 + 32'(i);
    gold[1] = 32'h2408_0001;
  end

  // Every cycle: check the DUT against the model and work out the model's next state.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_f_rvalid", 64'(f_rvalid), 64'd0);
      chk("rst_f_rdata", 64'(f_rdata), 64'd0);
      chk("rst_f_err", 64'(f_err), 64'd0);
      chk("rst_l_err", 64'(l_err), 64'd0);
      chk("rst_load_cnt", 64'(load_cnt), 64'd0);
      nx_pend = 0; nx_perr = 0; nx_lerr = 0; nx_we = 0; nx_turn = 1;
      nx_pdata = 0; nx_wdata = 0; nx_cnt = 0; nx_widx = 0;
    end else begin
`ifdef IM_ARB_RR_EN
      e_f = f_req && (!l_valid || m_fetch_turn);
`else
      e_f = f_req;
`endif
      e_l = l_valid && !e_f;
      fin = in_rng(f_addr);
      lin = in_rng(l_addr);
      chk("f_gnt", 64'(f_gnt), 64'(e_f));
      chk("l_ready", 64'(l_ready), 64'(e_l));
      chk("mem_en", 64'(mem_en), 64'((e_f && fin) || (e_l && lin)));
      chk("mem_we", 64'(mem_we), 64'(e_l && lin));
      if (e_f && fin) chk("mem_addr_fetch", 64'(mem_addr), 64'(widx(f_addr)));
      if (e_l && lin) begin
        chk("mem_addr_load", 64'(mem_addr), 64'(widx(l_addr)));
        chk("mem_wdata", 64'(mem_wdata), 64'(l_wdata));
      end
      chk("f_rvalid", 64'(f_rvalid), 64'(m_pend));
      chk("f_err", 64'(f_err), 64'(m_pend && m_perr));
      chk("f_rdata", 64'(f_rdata), (m_pend && !m_perr) ? 64'(m_pdata) : 64'd0);
      chk("l_err", 64'(l_err), 64'(m_lerr));
      chk("load_cnt", 64'(load_cnt), 64'(m_cnt));
      nx_pend  = e_f;
      nx_perr  = e_f && !fin;
      nx_pdata = (e_f && fin) ? gold[widx(f_addr)] : 32'h0;
      nx_lerr  = e_l && !lin;
      nx_we    = e_l && lin;
      nx_widx  = nx_we ? widx(l_addr) : 0;
      nx_wdata = l_wdata;
      nx_cnt   = (nx_we && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      nx_turn  = (f_req && l_valid) ? !m_fetch_turn : m_fetch_turn;
    end
  end

  // Move the model to its next state on the clock edge. Reset clears the model.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend <= 0; m_perr <= 0; m_lerr <= 0; m_cnt <= 0;
      m_fetch_turn <= 1; m_pdata <= 0;
    end else begin
      m_pend <= nx_pend; m_perr <= nx_perr; m_pdata <= nx_pdata;
      m_lerr <= nx_lerr; m_cnt <= nx_cnt; m_fetch_turn <= nx_turn;
      if (nx_we) gold[nx_widx] <= nx_wdata;
    end
  end

  // Apply one cycle of inputs just after the rising edge, then wait for the falling edge.
  task automatic step(input logic fr, input logic [31:0] fa,
                      input logic lv, input logic [31:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    f_req = fr; f_addr = fa; l_valid = lv; l_addr = la; l_wdata = ld;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [3:0] exp_f;
  int         exp_cnt;

  initial begin
    reset_n = 1'b0;
    f_req = 0; f_addr = 0; l_valid = 0; l_addr = 0; l_wdata = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Fetch word 1
    step(1, 32'h0000_3004, 0, 0, 0);
    chk("lit_fetch_gnt", 64'(f_gnt), 64'd1);
    chk("lit_fetch_addr", 64'(mem_addr), 64'd1);
    idle();
    chk("lit_fetch_rvalid", 64'(f_rvalid), 64'd1);
    chk("lit_fetch_rdata", 64'(f_rdata), 64'h2408_0001);
    chk("lit_fetch_err", 64'(f_err), 64'd0);

    // Load to word 2, then read it back
    step(0, 0, 1, 32'h0000_3008, 32'hDEAD_BEEF);
    chk("lit_load_ready", 64'(l_ready), 64'd1);
    chk("lit_load_we", 64'(mem_we), 64'd1);
    chk("lit_load_addr", 64'(mem_addr), 64'd2);
    chk("lit_load_cnt0", 64'(load_cnt), 64'd0);
    step(1, 32'h0000_3008, 0, 0, 0);
    chk("lit_load_cnt1", 64'(load_cnt), 64'd1);
    idle();
    chk("lit_readback", 64'(f_rdata), 64'hDEAD_BEEF);

    // Out-of-range fetches, then the last and first-past-end words
    step(1, 32'h0000_2FFC, 0, 0, 0);
    chk("lit_below_base_en", 64'(mem_en), 64'd0);
    step(1, 32'h0000_3002, 0, 0, 0);
    chk("lit_misalign_en", 64'(mem_en), 64'd0);
    chk("lit_below_base_err", 64'(f_err), 64'd1);
    chk("lit_below_base_rdata", 64'(f_rdata), 64'd0);
    step(1, 32'h0000_6FFC, 0, 0, 0);
    chk("lit_misalign_err", 64'(f_err), 64'd1);
    chk("lit_last_word_addr", 64'(mem_addr), 64'd4095);
    step(1, 32'h0000_7000, 0, 0, 0);
    chk("lit_last_word_rdata", 64'(f_rdata), 64'h1000_0FFF);
    idle();
    chk("lit_past_end_err", 64'(f_err), 64'd1);
    idle();
    chk("lit_rvalid_drop", 64'(f_rvalid), 64'd0);

    // Conflicting requests held for four cycles
`ifdef IM_ARB_RR_EN
    exp_f = 4'b0101;
    exp_cnt = 3;
`else
    exp_f = 4'b1111;
    exp_cnt = 1;
`endif
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h0000_3000 + 32'(4 * i), 1, 32'h0000_3010 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      chk("lit_conflict_gnt", 64'(f_gnt), 64'(exp_f[i]));
    end
    idle();
    chk("lit_conflict_cnt", 64'(load_cnt), 64'(exp_cnt));

    // Out-of-range loads: index 4096 and a misaligned address
    step(0, 0, 1, 32'h0000_7000, 32'h1234_5678);
    chk("lit_oor_load_ready", 64'(l_ready), 64'd1);
    chk("lit_oor_load_en", 64'(mem_en), 64'd0);
    step(0, 0, 1, 32'h0000_3001, 32'h1);
    chk("lit_oor_load_lerr", 64'(l_err), 64'd1);
    idle();
    chk("lit_misalign_lerr", 64'(l_err), 64'd1);
    chk("lit_oor_cnt", 64'(load_cnt), 64'(exp_cnt));
    idle();
    chk("lit_lerr_pulse", 64'(l_err), 64'd0);

    // Back-to-back fetches interleaved with loads
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 2) step(0, 0, 1, 32'h0000_3100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
      else            step(1, 32'h0000_3100 + 32'(4 * (i - 1)), 0, 0, 0);
    end
    idle();

    // Reset in the cycle after a fetch grant
    step(1, 32'h0000_3004, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0; f_req = 0;
    @(negedge clk);
    chk("lit_rst_rvalid", 64'(f_rvalid), 64'd0);
    chk("lit_rst_cnt", 64'(load_cnt), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_rvalid", 64'(f_rvalid), 64'd0);
    idle();
    chk("lit_post_rst_rvalid2", 64'(f_rvalid), 64'd0);
    // The first conflict after reset goes to fetch
    step(1, 32'h0000_3000, 1, 32'h0000_3000, 32'h5);
    chk("lit_post_rst_conflict", 64'(f_gnt), 64'd1);
    idle();

    // Drive the write counter into saturation
    for (int i = 0; i < 65540; i++)
      step(0, 0, 1, 32'h0000_3000 + 32'(4 * (i % WORDS)), 32'(i));
    idle();
    chk("lit_cnt_saturated", 64'(load_cnt), 64'hFFFF);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/im_arbiter.md
IM_ARBITER -- requirements
Module: im_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_3000, byte address of instruction-memory word 0.
REQ-002 Parameter DEPTH_LOG2, default 12, log2 of memory depth in 32-bit words.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 f_req  input  1  fetch request; f_addr  input  32  fetch byte address.
REQ-006 f_gnt  output  1  fetch granted this cycle (combinational).
REQ-007 f_rvalid  output  1  read data valid; f_rdata  output  32  read data; f_err  output  1  fetch address error.
REQ-008 l_valid  input  1  load write valid; l_addr  input  32  load byte address; l_wdata  input  32  load data.
REQ-009 l_ready  output  1  load write accepted this cycle (combinational).
REQ-010 l_err  output  1  registered one-cycle pulse, accepted load was out of range.
REQ-011 load_cnt  output  16  count of successful memory writes.
REQ-012 mem_en, mem_we  output  1 each; mem_addr  output  DEPTH_LOG2; mem_wdata  output  32; mem_rdata  input  32  (synchronous single-port RAM, 1-cycle read latency).

Function
REQ-013 At most one of f_gnt, l_ready SHALL be high in any cycle.
REQ-014 Only f_req: f_gnt=1; only l_valid: l_ready=1; neither: both 0, mem_en=0.
REQ-015 Conflict (f_req and l_valid): fetch wins unless IM_ARB_RR_EN is defined (REQ-026).
REQ-016 Word index = (addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits, drives mem_addr.
REQ-017 Address is in range iff addr >= BASE_ADDR, addr[1:0]==0 and (addr - BASE_ADDR) < 4 * 2^DEPTH_LOG2.
REQ-018 Granted in-range fetch: mem_en=1, mem_we=0 in grant cycle; next cycle f_rvalid=1, f_rdata=mem_rdata, f_err=0.
REQ-019 Granted out-of-range fetch: mem_en=0; next cycle f_rvalid=1, f_err=1, f_rdata=0.
REQ-020 f_rvalid SHALL be 0 in any cycle not following a fetch grant; f_rdata SHALL be 0 when f_rvalid=0.
REQ-021 Accepted in-range load: mem_en=1, mem_we=1, mem_wdata=l_wdata in acceptance cycle; load_cnt increments by 1.
REQ-022 Accepted out-of-range load: no memory access, load_cnt unchanged, l_err=1 in the next cycle.
REQ-023 load_cnt saturates at 16'hFFFF (no wrap).
REQ-024 Back-to-back grants SHALL be supported every cycle (full throughput, no bubbles).

Reset
REQ-025 While reset_n=0: f_rvalid, f_rdata, f_err, l_err, load_cnt = 0; round-robin pointer = fetch; a read in flight at reset assertion SHALL NOT produce f_rvalid after release.

Configuration
REQ-026 Macro IM_ARB_RR_EN: when defined, conflicts alternate using a 1-bit pointer that flips to the other requester after each conflict grant (first conflict after reset goes to fetch); when undefined, fetch always wins and no pointer register exists.

Verification
REQ-027 Fetch 32'h0000_3004, mem word 1 = 32'h2408_0001 -> cycle T f_gnt=1, mem_addr=1; T+1 f_rvalid=1, f_rdata=32'h2408_0001, f_err=0.
REQ-028 Load l_addr=32'h0000_3008, l_wdata=32'hDEAD_BEEF, no fetch -> l_ready=1, mem_we=1, mem_addr=2, load_cnt 0->1.
REQ-029 Fetch 32'h0000_2FFC then 32'h0000_3002 -> each next cycle f_rvalid=1, f_err=1, f_rdata=0, mem_en=0.
REQ-030 f_req and l_valid held high 4 cycles -> without IM_ARB_RR_EN grants F,F,F,F; with it F,L,F,L.
REQ-031 Load at 32'h0000_7000 (index 4096) -> l_ready=1, mem_en=0, l_err=1 next cycle, load_cnt unchanged.
REQ-032 reset_n low in cycle after fetch grant -> f_rvalid stays 0 through and after release; load_cnt=0.
